// File: rtl/reset_sequencer.sv
// Ordered SoC reset sequencer: asserts all domains, releases memory, peripherals, then core,
// waits for a core heartbeat with bounded retries, and latches a fault when retries run out.
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned STAGE_GAP     = 64,
    parameter int unsigned ALIVE_TIMEOUT = 1_000_000,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sys_reset_req,
    input  logic             ext_reset_btn_n,
    input  logic             core_alive,
    output logic             mem_rst_n,
    output logic             periph_rst_n,
    output logic             core_rst_n,
    output logic             timer_hold,
    output logic             seq_busy,
    output logic             alive_fail,
    output logic             fault,
    output logic [CNT_W-1:0] reset_count
);

    localparam int unsigned MaxHG   = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int unsigned MaxWait = (ALIVE_TIMEOUT > MaxHG) ? ALIVE_TIMEOUT : MaxHG;
    localparam int unsigned CycW    = $clog2(MaxWait + 1);
    localparam int unsigned RetryW  = $clog2(MAX_RETRY + 1);

    localparam logic [CycW-1:0]   HoldLast  = CycW'(HOLD_CYCLES - 1);
    localparam logic [CycW-1:0]   GapLast   = CycW'(STAGE_GAP - 1);
    localparam logic [CycW-1:0]   AliveLast = CycW'(ALIVE_TIMEOUT - 1);
    localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRY);

    typedef enum logic [2:0] {
        StHold,
        StRelMem,
        StRelPeriph,
        StWaitAlive,
        StIdle,
        StFault
    } state_e;

    state_e            state_q, state_d;
    logic [CycW-1:0]   cyc_q, cyc_d;
    logic [RetryW-1:0] retry_q, retry_d, retry_inc;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mem_q, mem_d;
    logic              periph_q, periph_d;
    logic              core_q, core_d;
    logic              busy_q, busy_d;
    logic              afail_q, afail_d;
    logic              fault_q, fault_d;

    // Button synchronizer plus one extra stage for falling-edge detection
    logic btn_meta_q, btn_sync_q, btn_prev_q;
    logic sys_prev_q;
    logic sys_rise, btn_fall, accept;

    assign sys_rise  = sys_reset_req & ~sys_prev_q;
    assign btn_fall  = btn_prev_q & ~btn_sync_q;
    assign retry_inc = retry_q + RetryW'(1);

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        retry_d  = retry_q;
        count_d  = count_q;
        mem_d    = mem_q;
        periph_d = periph_q;
        core_d   = core_q;
        busy_d   = busy_q;
        afail_d  = 1'b0;
        fault_d  = fault_q;
        accept   = 1'b0;

        unique case (state_q)
            StHold: begin
                cyc_d = cyc_q + CycW'(1);
                if (cyc_q == HoldLast) begin
                    state_d = StRelMem;
                    cyc_d   = '0;
                    mem_d   = 1'b1;
                end
            end
            StRelMem: begin
                cyc_d = cyc_q + CycW'(1);
                if (cyc_q == GapLast) begin
                    state_d  = StRelPeriph;
                    cyc_d    = '0;
                    periph_d = 1'b1;
                end
            end
            StRelPeriph: begin
                cyc_d = cyc_q + CycW'(1);
                if (cyc_q == GapLast) begin
                    state_d = StWaitAlive;
                    cyc_d   = '0;
                    core_d  = 1'b1;
                end
            end
            StWaitAlive: begin
                cyc_d = cyc_q + CycW'(1);
                if (core_alive) begin
                    state_d = StIdle;
                    cyc_d   = '0;
                    busy_d  = 1'b0;
                end else if (cyc_q == AliveLast) begin
                    afail_d = 1'b1;
                    retry_d = retry_inc;
                    cyc_d   = '0;
                    if (retry_inc < RetryMax) begin
                        state_d  = StHold;
                        mem_d    = 1'b0;
                        periph_d = 1'b0;
                        core_d   = 1'b0;
                    end else begin
                        state_d = StFault;
                        core_d  = 1'b0;
                        fault_d = 1'b1;
                    end
                end
            end
            StIdle:  accept = sys_rise | btn_fall;
            // Only the push-button may recover from a latched fault
            StFault: accept = btn_fall;
            default: state_d = StHold;
        endcase

        if (accept) begin
            state_d  = StHold;
            cyc_d    = '0;
            retry_d  = '0;
            mem_d    = 1'b0;
            periph_d = 1'b0;
            core_d   = 1'b0;
            busy_d   = 1'b1;
            fault_d  = 1'b0;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StHold;
            cyc_q      <= '0;
            retry_q    <= '0;
            count_q    <= '0;
            mem_q      <= 1'b0;
            periph_q   <= 1'b0;
            core_q     <= 1'b0;
            busy_q     <= 1'b1;
            afail_q    <= 1'b0;
            fault_q    <= 1'b0;
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
            btn_prev_q <= 1'b1;
            sys_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            retry_q    <= retry_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
            periph_q   <= periph_d;
            core_q     <= core_d;
            busy_q     <= busy_d;
            afail_q    <= afail_d;
            fault_q    <= fault_d;
            btn_meta_q <= ext_reset_btn_n;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
            sys_prev_q <= sys_reset_req;
        end
    end

    assign mem_rst_n    = mem_q;
    assign periph_rst_n = periph_q;
    assign core_rst_n   = core_q;
    assign seq_busy     = busy_q;
    assign timer_hold   = busy_q;
    assign alive_fail   = afail_q;
    assign fault        = fault_q;
    assign reset_count  = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer against a timestamp-based reference model.
module tb_reset_sequencer;

    localparam int H  = 8;
    localparam int G  = 4;
    localparam int T  = 16;
    localparam int MR = 2;
    localparam int R  = H + 2 * G;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sys_reset_req = 1'b0;
    logic       ext_reset_btn_n = 1'b1;
    logic       core_alive = 1'b0;
    logic       mem_rst_n, periph_rst_n, core_rst_n, timer_hold, seq_busy, alive_fail, fault;
    logic [7:0] reset_count;

    reset_sequencer #(
        .HOLD_CYCLES  (H),
        .STAGE_GAP    (G),
        .ALIVE_TIMEOUT(T),
        .MAX_RETRY    (MR),
        .CNT_W        (8)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .sys_reset_req  (sys_reset_req),
        .ext_reset_btn_n(ext_reset_btn_n),
        .core_alive     (core_alive),
        .mem_rst_n      (mem_rst_n),
        .periph_rst_n   (periph_rst_n),
        .core_rst_n     (core_rst_n),
        .timer_hold     (timer_hold),
        .seq_busy       (seq_busy),
        .alive_fail     (alive_fail),
        .fault          (fault),
        .reset_count    (reset_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned alive_pct = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: a sequence attempt is a start timestamp; outputs follow from elapsed time
    int m_n, m_start, m_retry, m_count;
    bit m_idle, m_fault, m_afail;
    bit p1, p2, p3, sys_prev;

    task automatic model_reset();
        m_n = 0; m_start = 0; m_retry = 0; m_count = 0;
        m_idle = 0; m_fault = 0; m_afail = 0;
        p1 = 1; p2 = 1; p3 = 1; sys_prev = 0;
    endtask

    task automatic start_seq();
        m_idle = 0; m_fault = 0; m_start = m_n; m_retry = 0;
        if (m_count < 255) m_count++;
    endtask

    task automatic model_step();
        bit bfall, srise;
        int e;
        m_n++;
        bfall = p3 && !p2;
        srise = sys_reset_req && !sys_prev;
        p3 = p2; p2 = p1; p1 = ext_reset_btn_n;
        sys_prev = sys_reset_req;
        m_afail = 0;
        if (m_idle) begin
            if (srise || bfall) start_seq();
        end else if (m_fault) begin
            if (bfall) start_seq();
        end else begin
            e = m_n - m_start;
            if (e > R && core_alive) begin
                m_idle = 1;
            end else if (e == R + T) begin
                m_afail = 1;
                m_retry++;
                if (m_retry < MR) m_start = m_n;
                else m_fault = 1;
            end
        end
    endtask

    function automatic logic [14:0] exp_vec();
        logic m, p, c, b, f;
        int e;
        if (m_idle) begin
            {m, p, c, b, f} = 5'b11100;
        end else if (m_fault) begin
            {m, p, c, b, f} = 5'b11011;
        end else begin
            e = m_n - m_start;
            m = (e >= H);
            p = (e >= H + G);
            c = (e >= R);
            b = 1'b1;
            f = 1'b0;
        end
        return {m, p, c, b, b, m_afail, f, m_count[7:0]};
    endfunction

    logic [14:0] dut_vec;
    assign dut_vec = {mem_rst_n, periph_rst_n, core_rst_n, seq_busy, timer_hold, alive_fail,
                      fault, reset_count};

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 core_alive = ($urandom_range(0, 99) < alive_pct);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("outs", 32'(dut_vec), 32'(exp_vec()));
        end
    end

    task automatic pulse_sys(input int len);
        sys_reset_req = 1'b1;
        repeat (len) @(negedge clk);
        sys_reset_req = 1'b0;
    endtask

    task automatic press_btn(input int len);
        ext_reset_btn_n = 1'b0;
        repeat (len) @(negedge clk);
        ext_reset_btn_n = 1'b1;
    endtask

    task automatic both_req();
        ext_reset_btn_n = 1'b0;
        repeat (2) @(negedge clk);
        sys_reset_req = 1'b1;
        @(negedge clk);
        ext_reset_btn_n = 1'b1;
        repeat (3) @(negedge clk);
        sys_reset_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (!m_idle && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("wait_idle", 32'(m_idle), 32'd1);
    endtask

    task automatic wait_fault(input int budget);
        int c = 0;
        while (!m_fault && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("wait_fault", 32'(m_fault), 32'd1);
    endtask

    task automatic settle();
        alive_pct = 100;
        if (m_fault) press_btn(1);
        wait_idle(300);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c;
        int cnt0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Power-on: heartbeat only at edge 20
        while (m_n < 18) @(negedge clk);
        alive_pct = 100;
        @(negedge clk);
        alive_pct = 0;
        @(negedge clk);
        check("por_busy", 32'(seq_busy), 32'd0);
        check("por_count", 32'(reset_count), 32'd0);

        // Long watchdog level triggers once
        alive_pct = 100;
        pulse_sys(50);
        repeat (5) @(negedge clk);
        check("wd_count", 32'(reset_count), 32'd1);
        check("wd_busy", 32'(seq_busy), 32'd0);

        both_req();
        wait_idle(100);
        check("simul_count", 32'(reset_count), 32'd2);

        // Retry exhaustion into fault, then button recovery
        alive_pct = 0;
        pulse_sys(2);
        wait_fault(300);
        check("fault_flag", 32'(fault), 32'd1);
        check("fault_core", 32'(core_rst_n), 32'd0);
        pulse_sys(3);
        repeat (4) @(negedge clk);
        check("fault_sys_ign", 32'(reset_count), 32'd3);
        check("fault_held", 32'(fault), 32'd1);
        press_btn(2);
        @(negedge clk);
        check("fault_exit", 32'(fault), 32'd0);
        check("fault_exit_cnt", 32'(reset_count), 32'd4);
        check("fault_exit_core", 32'(core_rst_n), 32'd0);
        settle();

        for (int i = 0; i < 40; i++) begin
            alive_pct = $urandom_range(20, 100);
            case ($urandom_range(0, 3))
                0: pulse_sys($urandom_range(1, 30));
                1: press_btn($urandom_range(1, 5));
                2: both_req();
                default: repeat ($urandom_range(1, 40)) @(negedge clk);
            endcase
            repeat ($urandom_range(1, 25)) @(negedge clk);
        end
        settle();

        // Asynchronous reset in the middle of REL_MEM
        pulse_sys(1);
        c = 0;
        while ((m_n - m_start) != H + 2 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("arst_reach", 32'(mem_rst_n & ~periph_rst_n), 32'd1);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 check("arst_vec", 32'(dut_vec), 32'({7'b0001100, 8'h00}));
        @(negedge clk);
        rstn = 1'b1;
        wait_idle(200);
        check("arst_count", 32'(reset_count), 32'd0);

        // Saturation
        cnt0 = 0;
        repeat (300) begin
            pulse_sys(1);
            wait_idle(100);
            cnt0++;
        end
        repeat (2) @(negedge clk);
        check("sat_count", 32'(reset_count), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
